// File: rtl/fpu_operand_unpack.sv
// Input stage of the binary32 add/sub datapath: classifies and unpacks two operands
// behind a 2-entry skid buffer. Define FPU_UNPACK_FTZ_EN to flush subnormals to zero.
module fpu_operand_unpack #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic             sign_a,
  output logic             sign_b_eff,
  output logic [7:0]       exp_a,
  output logic [7:0]       exp_b,
  output logic [22:0]      frac_a,
  output logic [22:0]      frac_b,
  output logic [23:0]      mant_a,
  output logic [23:0]      mant_b,
  output logic             is_zero_a,
  output logic             is_zero_b,
  output logic             is_inf_a,
  output logic             is_inf_b,
  output logic             is_nan_a,
  output logic             is_nan_b,
  output logic             is_sub_a,
  output logic             is_sub_b,
  output logic             is_snan
);

  typedef struct packed {
    logic [22:0] frac;
    logic [23:0] mant;
    logic        zero;
    logic        inf;
    logic        nan;
    logic        sub;
    logic        snan;
  } op_t;

  typedef struct packed {
    logic             sign_a;
    logic             sign_b_eff;
    logic [7:0]       exp_a;
    logic [7:0]       exp_b;
    op_t              op_a;
    op_t              op_b;
    logic [TAG_W-1:0] tag;
  } pair_t;

  function automatic op_t classify(input logic [7:0] e, input logic [22:0] f);
    op_t  o;
    logic exp_min;
    logic exp_max;
    logic frac_nz;
    exp_min = ~|e;
    exp_max = &e;
    frac_nz = |f;
`ifdef FPU_UNPACK_FTZ_EN
    // Subnormals collapse into signed zero; exponent field is already 0.
    o.frac = (exp_min & frac_nz) ? 23'd0 : f;
    o.zero = exp_min;
    o.sub  = 1'b0;
`else
    o.frac = f;
    o.zero = exp_min & ~frac_nz;
    o.sub  = exp_min & frac_nz;
`endif
    o.inf  = exp_max & ~frac_nz;
    o.nan  = exp_max & frac_nz;
    o.snan = exp_max & frac_nz & ~f[22];
    o.mant = {~exp_min, o.frac};
    return o;
  endfunction

  pair_t in_pair;
  pair_t main_q;
  pair_t skid_q;
  logic  out_valid_q;
  logic  in_ready_q;

  always_comb begin
    in_pair            = '0;
    in_pair.sign_a     = in_a[31];
    in_pair.sign_b_eff = in_b[31] ^ in_sub;
    in_pair.exp_a      = in_a[30:23];
    in_pair.exp_b      = in_b[30:23];
    in_pair.op_a       = classify(in_a[30:23], in_a[22:0]);
    in_pair.op_b       = classify(in_b[30:23], in_b[22:0]);
    in_pair.tag        = in_tag;
  end

  // in_ready_q low means the skid register holds a pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (!out_valid_q || out_ready) begin
      if (!in_ready_q) begin
        main_q      <= skid_q;
        out_valid_q <= 1'b1;
        in_ready_q  <= 1'b1;
      end else if (in_valid) begin
        main_q      <= in_pair;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (in_valid && in_ready_q) begin
      skid_q     <= in_pair;
      in_ready_q <= 1'b0;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_tag    = main_q.tag;
  assign sign_a     = main_q.sign_a;
  assign sign_b_eff = main_q.sign_b_eff;
  assign exp_a      = main_q.exp_a;
  assign exp_b      = main_q.exp_b;
  assign frac_a     = main_q.op_a.frac;
  assign frac_b     = main_q.op_b.frac;
  assign mant_a     = main_q.op_a.mant;
  assign mant_b     = main_q.op_b.mant;
  assign is_zero_a  = main_q.op_a.zero;
  assign is_zero_b  = main_q.op_b.zero;
  assign is_inf_a   = main_q.op_a.inf;
  assign is_inf_b   = main_q.op_b.inf;
  assign is_nan_a   = main_q.op_a.nan;
  assign is_nan_b   = main_q.op_b.nan;
  assign is_sub_a   = main_q.op_a.sub;
  assign is_sub_b   = main_q.op_b.sub;
  assign is_snan    = main_q.op_a.snan | main_q.op_b.snan;

endmodule
